// File: rtl/cache_pkg.sv
// cache_pkg
//   Shared types and constants for the cache miss controller: the FSM state
//   encoding, field widths of the CPU word address and line store, and the
//   bit positions of the tag/index/offset fields inside a CPU address.
package cache_pkg;

  localparam int TAG_W   = 9;
  localparam int IDX_W   = 5;
  localparam int LINE_W  = 64;
  localparam int WORD_W  = 16;
  localparam int DATA_W  = WORD_W;
  localparam int OFF_W   = 2;
  localparam int ADDR_W  = TAG_W + IDX_W + OFF_W;
  localparam int LADDR_W = TAG_W + IDX_W;
  localparam int CNT_W   = 16;

  // Field slice positions within cpu_addr: [15:7] tag, [6:2] index, [1:0] offset
  localparam int OFF_LSB = 0;
  localparam int IDX_LSB = OFF_LSB + OFF_W;
  localparam int TAG_LSB = IDX_LSB + IDX_W;

  typedef enum logic [2:0] {
    IDLE,
    COMPARE,
    WB,
    FILL,
    ALLOC,
    RESP
  } state_e;

endpackage

// File: rtl/cache_word_merge.sv
// cache_word_merge
//   Combinational word select / word merge on a 64-bit cache line.
//   Word k occupies bits [16k+15:16k].
//   Ports:
//     line   in  LINE_W  source line
//     off    in  OFF_W   word offset k
//     word   in  WORD_W  word to merge into slot k
//     merged out LINE_W  line with slot k replaced by word
//     sel    out WORD_W  word currently in slot k of line
module cache_word_merge
  import cache_pkg::*;
(
  input  logic [LINE_W-1:0] line,
  input  logic [OFF_W-1:0]  off,
  input  logic [WORD_W-1:0] word,
  output logic [LINE_W-1:0] merged,
  output logic [WORD_W-1:0] sel
);

  always_comb begin
    merged                       = line;
    merged[off*WORD_W +: WORD_W] = word;
    sel                          = line[off*WORD_W +: WORD_W];
  end

endmodule

// File: rtl/cache_miss_ctrl.sv
// cache_miss_ctrl
//   Single-outstanding-request cache controller between a 16-bit CPU word port
//   and a 2-way set-associative line store. Probes the store, writes back a
//   dirty victim, fills from main memory, allocates, and answers the CPU.
//   Ports:
//     clk, rst                   clock, asynchronous active-high reset
//     cpu_re/we/addr/wdata       CPU request (sampled only while cpu_ready)
//     cpu_ready/done/rdata       CPU handshake and read data
//     c_addr/re/we/toggle/wdirty line-store control, c_wdata line to write
//     c_rdata/tag/hit/dirty      line-store probe response
//     mem_re/we/addr/wdata       main-memory line transaction (held to mem_rdy)
//     mem_rdata/rdy              main-memory response
//     hit_cnt/miss_cnt           saturating statistics
//     mem_err                    sticky memory timeout flag
//   All outputs decode from registered state only.
module cache_miss_ctrl
  import cache_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cpu_re,
  input  logic               cpu_we,
  input  logic [ADDR_W-1:0]  cpu_addr,
  input  logic [WORD_W-1:0]  cpu_wdata,
  output logic               cpu_ready,
  output logic               cpu_done,
  output logic [WORD_W-1:0]  cpu_rdata,
  output logic [LADDR_W-1:0] c_addr,
  output logic               c_re,
  output logic               c_we,
  output logic               c_toggle,
  output logic               c_wdirty,
  output logic [LINE_W-1:0]  c_wdata,
  input  logic [LINE_W-1:0]  c_rdata,
  input  logic [TAG_W-1:0]   c_tag,
  input  logic               c_hit,
  input  logic               c_dirty,
  output logic               mem_re,
  output logic               mem_we,
  output logic [LADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0]  mem_wdata,
  input  logic [LINE_W-1:0]  mem_rdata,
  input  logic               mem_rdy,
  output logic [CNT_W-1:0]   hit_cnt,
  output logic [CNT_W-1:0]   miss_cnt,
  output logic               mem_err
);

  localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] TMO = WCNT_W'(MEM_TIMEOUT);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   req_addr_q;
  logic [WORD_W-1:0]   req_wdata_q;
  logic                req_wr_q;
  logic                hit_q;
  logic [LINE_W-1:0]   line_q;     // victim/hit line after COMPARE, fill line after FILL
  logic [TAG_W-1:0]    vtag_q;
  logic [WCNT_W-1:0]   wait_q;
  logic [CNT_W-1:0]    hit_cnt_q, miss_cnt_q;
  logic                mem_err_q;

  logic                mem_wait;
  logic                mem_tmo;
  logic                mem_done;
  logic [LINE_W-1:0]   merged_line;
  logic [WORD_W-1:0]   sel_word;
  logic [LADDR_W-1:0]  req_laddr;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  assign req_laddr = req_addr_q[ADDR_W-1:IDX_LSB];
  assign mem_wait  = (state_q == WB) || (state_q == FILL);
  // A timeout completes the memory transaction exactly as mem_rdy would.
  assign mem_tmo   = mem_wait && !mem_rdy && (wait_q == TMO);
  assign mem_done  = mem_wait && (mem_rdy || (wait_q == TMO));

  cache_word_merge u_merge (
    .line   (line_q),
    .off    (req_addr_q[OFF_LSB +: OFF_W]),
    .word   (req_wdata_q),
    .merged (merged_line),
    .sel    (sel_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wait_q     <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      // Counter runs only while stalled in WB/FILL; any other cycle (including
      // the transition into WB or FILL) leaves it at zero.
      if (mem_wait && !mem_done) wait_q <= wait_q + 1'b1;
      else                       wait_q <= '0;
      if (state_q == COMPARE) begin
        if (c_hit) hit_cnt_q  <= sat_inc(hit_cnt_q);
        else       miss_cnt_q <= sat_inc(miss_cnt_q);
      end
      if (mem_tmo) mem_err_q <= 1'b1;
    end
  end

  // Request and line data carry no reset; they are always written before use.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && (cpu_re || cpu_we)) begin
      req_addr_q  <= cpu_addr;
      req_wdata_q <= cpu_wdata;
      req_wr_q    <= cpu_we;
    end
    if (state_q == COMPARE) begin
      line_q <= c_rdata;
      vtag_q <= c_tag;
      hit_q  <= c_hit;
    end
    if (state_q == FILL && mem_done) line_q <= mem_rdata;
  end

  always_comb begin
    state_d   = state_q;
    cpu_ready = 1'b0;
    cpu_done  = 1'b0;
    cpu_rdata = '0;
    c_addr    = '0;
    c_re      = 1'b0;
    c_we      = 1'b0;
    c_toggle  = 1'b0;
    c_wdirty  = 1'b0;
    c_wdata   = '0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (state_q)
      IDLE: begin
        cpu_ready = 1'b1;
        if (cpu_re || cpu_we) state_d = COMPARE;
      end
      COMPARE: begin
        c_re   = 1'b1;
        c_addr = req_laddr;
        if (c_hit)        state_d = RESP;
        else if (c_dirty) state_d = WB;
        else              state_d = FILL;
      end
      WB: begin
        mem_we    = 1'b1;
        mem_addr  = {vtag_q, req_addr_q[IDX_LSB +: IDX_W]};
        mem_wdata = line_q;
        if (mem_done) state_d = FILL;
      end
      FILL: begin
        mem_re   = 1'b1;
        mem_addr = req_laddr;
        if (mem_done) state_d = ALLOC;
      end
      ALLOC: begin
        c_we     = 1'b1;
        c_toggle = 1'b1;
        c_addr   = req_laddr;
        c_wdirty = req_wr_q;
        c_wdata  = req_wr_q ? merged_line : line_q;
        state_d  = RESP;
      end
      RESP: begin
        cpu_done = 1'b1;
        if (!req_wr_q) begin
          cpu_rdata = sel_word;
        end else if (hit_q) begin
          // Misses already stored the merged line in ALLOC.
          c_we     = 1'b1;
          c_wdirty = 1'b1;
          c_addr   = req_laddr;
          c_wdata  = merged_line;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
  assign mem_err  = mem_err_q;

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// tb_cache_miss_ctrl
//   Directed-vector bench for cache_miss_ctrl. The line store and main memory
//   are represented by directly driven response inputs.
module tb_cache_miss_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_re, cpu_we;
  logic [15:0] cpu_addr, cpu_wdata;
  logic        cpu_ready, cpu_done;
  logic [15:0] cpu_rdata;
  logic [13:0] c_addr;
  logic        c_re, c_we, c_toggle, c_wdirty;
  logic [63:0] c_wdata, c_rdata;
  logic [8:0]  c_tag;
  logic        c_hit, c_dirty;
  logic        mem_re, mem_we;
  logic [13:0] mem_addr;
  logic [63:0] mem_wdata, mem_rdata;
  logic        mem_rdy;
  logic [15:0] hit_cnt, miss_cnt;
  logic        mem_err;

  int vec_cnt = 0;
  int err_cnt = 0;

  cache_miss_ctrl #(.MEM_TIMEOUT(255)) dut (
    .clk(clk), .rst(rst),
    .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
    .c_addr(c_addr), .c_re(c_re), .c_we(c_we), .c_toggle(c_toggle),
    .c_wdirty(c_wdirty), .c_wdata(c_wdata), .c_rdata(c_rdata), .c_tag(c_tag),
    .c_hit(c_hit), .c_dirty(c_dirty),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rdy(mem_rdy),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int fill_cyc;
    int guard;
    logic done_seen;

    rst = 1'b1; cpu_re = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    c_rdata = '0; c_tag = '0; c_hit = 0; c_dirty = 0;
    mem_rdata = '0; mem_rdy = 0;
    tick; tick;
    rst = 1'b0;
    tick;

    // Reset state
    chk("rst_ready", cpu_ready, 1);
    chk("rst_done", cpu_done, 0);
    chk("rst_rdata", cpu_rdata, 0);
    chk("rst_strobes", {c_re, c_we, mem_re, mem_we}, 0);
    chk("rst_hits", hit_cnt, 0);
    chk("rst_miss", miss_cnt, 0);
    chk("rst_err", mem_err, 0);

    // Clean read miss at 0x0084
    c_rdata = 64'hFFFF_EEEE_DDDD_CCCC; c_hit = 0; c_dirty = 0; c_tag = 9'h055;
    cpu_re = 1; cpu_addr = 16'h0084;
    tick;
    chk("m1_cre", c_re, 1);
    chk("m1_caddr", c_addr, 14'h021);
    chk("m1_notready", cpu_ready, 0);
    tick;
    chk("m1_mre", mem_re, 1);
    chk("m1_nowb", mem_we, 0);
    chk("m1_maddr", mem_addr, 14'h021);
    tick; tick; tick;
    chk("m1_hold", mem_re, 1);
    mem_rdy = 1; mem_rdata = 64'h4444_3333_2222_1111;
    tick;
    mem_rdy = 0;
    chk("m1_alloc_we", c_we, 1);
    chk("m1_alloc_tgl", c_toggle, 1);
    chk("m1_alloc_dirty", c_wdirty, 0);
    chk("m1_alloc_data", c_wdata, 64'h4444_3333_2222_1111);
    chk("m1_alloc_mre", mem_re, 0);
    tick;
    chk("m1_done", cpu_done, 1);
    chk("m1_rdata", cpu_rdata, 16'h1111);
    chk("m1_misscnt", miss_cnt, 1);
    cpu_re = 0;
    tick;
    chk("m1_idle", {cpu_ready, cpu_done}, 2'b10);

    // Read hit at 0x0087
    c_hit = 1; c_rdata = 64'h4444_3333_2222_1111;
    cpu_re = 1; cpu_addr = 16'h0087;
    tick;
    chk("h_cre", c_re, 1);
    chk("h_caddr", c_addr, 14'h021);
    tick;
    chk("h_done", cpu_done, 1);
    chk("h_rdata", cpu_rdata, 16'h4444);
    chk("h_nomem", {mem_re, mem_we}, 0);
    chk("h_nowe", c_we, 0);
    chk("h_hitcnt", hit_cnt, 1);
    cpu_re = 0;
    tick;
    chk("h_ready", cpu_ready, 1);
    chk("h_rdata0", cpu_rdata, 0);

    // Write hit at 0x0085
    cpu_we = 1; cpu_addr = 16'h0085; cpu_wdata = 16'hBEEF;
    tick;
    tick;
    chk("wh_done", cpu_done, 1);
    chk("wh_we", c_we, 1);
    chk("wh_tgl", c_toggle, 0);
    chk("wh_dirty", c_wdirty, 1);
    chk("wh_data", c_wdata, 64'h4444_3333_BEEF_1111);
    chk("wh_caddr", c_addr, 14'h021);
    chk("wh_rdata", cpu_rdata, 0);
    chk("wh_hitcnt", hit_cnt, 2);
    cpu_we = 0;
    tick;

    // Dirty write miss at 0x0086, victim tag 0x1A5
    c_hit = 0; c_dirty = 1; c_tag = 9'h1A5; c_rdata = 64'hAAAA_BBBB_CCCC_DDDD;
    cpu_we = 1; cpu_addr = 16'h0086; cpu_wdata = 16'h5A5A;
    tick;
    tick;
    chk("dm_mwe", mem_we, 1);
    chk("dm_mre0", mem_re, 0);
    chk("dm_waddr", mem_addr, 14'h34A1);
    chk("dm_wdata", mem_wdata, 64'hAAAA_BBBB_CCCC_DDDD);
    tick;
    chk("dm_whold", {mem_we, mem_addr}, {1'b1, 14'h34A1});
    mem_rdy = 1;
    tick;
    mem_rdy = 0;
    chk("dm_fill", {mem_re, mem_we}, 2'b10);
    chk("dm_raddr", mem_addr, 14'h021);
    tick;
    chk("dm_fhold", mem_re, 1);
    mem_rdy = 1; mem_rdata = 64'h1234_5678_9ABC_DEF0;
    tick;
    mem_rdy = 0;
    chk("dm_alloc", {c_we, c_toggle, c_wdirty}, 3'b111);
    chk("dm_adata", c_wdata, 64'h1234_5A5A_9ABC_DEF0);
    tick;
    chk("dm_done", cpu_done, 1);
    chk("dm_nowe", c_we, 0);
    chk("dm_misscnt", miss_cnt, 2);
    cpu_we = 0;
    tick;

    // Async reset in the middle of FILL
    c_dirty = 0;
    cpu_re = 1; cpu_addr = 16'h0084;
    tick;
    tick;
    chk("ra_fill", mem_re, 1);
    #2 rst = 1;
    #1;
    chk("ra_mre", mem_re, 0);
    chk("ra_ready", cpu_ready, 1);
    chk("ra_cnts", {hit_cnt, miss_cnt}, 0);
    cpu_re = 0;
    tick;
    rst = 0;
    done_seen = 0;
    for (int i = 0; i < 6; i++) begin
      done_seen |= cpu_done;
      tick;
    end
    chk("ra_nodone", done_seen, 0);

    // Memory timeout during FILL
    mem_rdata = 64'h0BAD_0BAD_0BAD_F00D; mem_rdy = 0;
    cpu_re = 1; cpu_addr = 16'h0084;
    tick;
    tick;
    fill_cyc = 0;
    guard = 0;
    while (!cpu_done && guard < 400) begin
      if (mem_re) fill_cyc++;
      if (fill_cyc == 200) chk("to_early", mem_err, 0);
      tick;
      guard++;
    end
    chk("to_done", cpu_done, 1);
    chk("to_err", mem_err, 1);
    chk("to_len", (fill_cyc >= 255), 1);
    chk("to_rdata", cpu_rdata, 16'hF00D);
    cpu_re = 0;
    repeat (3) tick;
    chk("to_sticky", mem_err, 1);
    rst = 1;
    #1;
    chk("to_rstclr", mem_err, 0);
    tick;
    rst = 0;
    tick;

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
